// File: rtl/abr_packer_arb_pkg.sv
// -----------------------------------------------------------------------------
// abr_packer_arb_pkg
// Shared types and constants for the round-robin packer arbiter.
//   arb_state_e       : arbiter state (idle / grant locked to one requester)
//   DefTimeoutCycles  : default idle-owner cycles before a forced release
//                       (only meaningful when ABR_PACKER_ARB_TIMEOUT_EN is set)
// -----------------------------------------------------------------------------
package abr_packer_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int DefTimeoutCycles = 64;

endpackage

// File: rtl/abr_packer_arb_if.sv
// -----------------------------------------------------------------------------
// abr_packer_arb_if
// Handshake bundle between the requesters, the arbiter and the packer FIFO.
//   req_valid_i / req_data_i / req_last_i : requester beats (slice k = req k)
//   req_ready_o                           : per-requester accept
//   pk_wvalid_o / pk_wdata_o / pk_wready_i: packer write port
//   pk_clr_o                              : packer clear
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters + packer)
// -----------------------------------------------------------------------------
interface abr_packer_arb_if #(
    parameter int NumReq = 4,
    parameter int InW    = 32
);
    logic [NumReq-1:0]     req_valid_i;
    logic [NumReq*InW-1:0] req_data_i;
    logic [NumReq-1:0]     req_last_i;
    logic [NumReq-1:0]     req_ready_o;
    logic                  pk_wvalid_o;
    logic [InW-1:0]        pk_wdata_o;
    logic                  pk_wready_i;
    logic                  pk_clr_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, pk_wready_i,
        output req_ready_o, pk_wvalid_o, pk_wdata_o, pk_clr_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, pk_wready_i,
        input  req_ready_o, pk_wvalid_o, pk_wdata_o, pk_clr_o
    );
endinterface

// File: rtl/abr_packer_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// abr_packer_arb_rr_pick
// Combinational rotating-priority picker: returns the first set bit of req_i
// scanning upward from rr_ptr_i with wrap-around.
//   req_i    : request vector
//   rr_ptr_i : index with highest priority
//   any_o    : at least one request is set
//   idx_o    : winning index (0 when any_o is low)
// -----------------------------------------------------------------------------
module abr_packer_arb_rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic              any_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [IdxW:0] cand;

    assign any_o = |req_i;

    // Walk offsets from the farthest to the nearest so the closest set bit
    // to rr_ptr_i is the last one written and therefore wins.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr_i} + (IdxW + 1)'(off);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (req_i[cand[IdxW-1:0]]) begin
                idx_o = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/abr_packer_arb.sv
// -----------------------------------------------------------------------------
// abr_packer_arb
// Round-robin arbiter that shares one packer FIFO write port between NumReq
// requesters. The grant is locked for a whole packet (until the last beat is
// accepted), then the round-robin pointer moves past the finished owner.
// Ports:
//   clk_i, rst_b (async, active low), clr_i (synchronous abort)
//   bus           : abr_packer_arb_if.slave (requester + packer handshakes)
//   gnt_id_o      : current / last owner index
//   busy_o        : a grant is locked
//   beat_cnt_o    : beats accepted in the current packet, including a beat
//                   being accepted this cycle
//   timeout_err_o : one-cycle pulse on a forced release
// Optional feature macro: ABR_PACKER_ARB_TIMEOUT_EN
//   When defined, an owner that keeps valid low for TimeoutCycles cycles is
//   forcibly released and the packer is cleared. When undefined the lock is
//   held indefinitely and timeout_err_o is tied low.
// -----------------------------------------------------------------------------
module abr_packer_arb
    import abr_packer_arb_pkg::*;
#(
    parameter  int NumReq        = 4,
    parameter  int InW           = 32,
    parameter  int CntW          = 16,
    parameter  int TimeoutCycles = DefTimeoutCycles,
    localparam int IdxW          = $clog2(NumReq)
) (
    input  logic                 clk_i,
    input  logic                 rst_b,
    input  logic                 clr_i,
    abr_packer_arb_if.slave      bus,
    output logic [IdxW-1:0]      gnt_id_o,
    output logic                 busy_o,
    output logic [CntW-1:0]      beat_cnt_o,
    output logic                 timeout_err_o
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] gnt_next;
    logic [IdxW-1:0] pick_idx;
    logic            pick_any;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            owner_valid;
    logic            owner_last;
    logic            steer;
    logic            accept;
    logic            timeout;

    abr_packer_arb_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i    (bus.req_valid_i),
        .rr_ptr_i (rr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx)
    );

    assign owner_valid = bus.req_valid_i[gnt_q];
    assign owner_last  = bus.req_last_i[gnt_q];
    assign gnt_next    = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ABR_PACKER_ARB_TIMEOUT_EN
    localparam int IdleW = $clog2(TimeoutCycles + 1);

    logic [IdleW-1:0] idle_q, idle_d;

    // Counts consecutive LOCK cycles where the owner shows no valid; any
    // valid beat, exit from LOCK or a clear restarts it.
    always_comb begin
        idle_d = '0;
        if (state_q == ARB_LOCK && !clr_i && !timeout && !owner_valid) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign timeout = (state_q == ARB_LOCK) && (idle_q == IdleW'(TimeoutCycles));
`else
    assign timeout = 1'b0;
`endif

    // The write port is only steered while locked; a clear or a forced
    // release blocks the path so nothing is accepted in that cycle.
    assign steer  = (state_q == ARB_LOCK) && !clr_i && !timeout;
    assign accept = steer && owner_valid && bus.pk_wready_i;

    always_comb begin
        bus.req_ready_o = '0;
        bus.pk_wvalid_o = 1'b0;
        bus.pk_wdata_o  = '0;
        if (steer) begin
            bus.pk_wvalid_o        = owner_valid;
            bus.pk_wdata_o         = bus.req_data_i[gnt_q*InW +: InW];
            bus.req_ready_o[gnt_q] = bus.pk_wready_i;
        end
    end

    assign bus.pk_clr_o  = clr_i || timeout;
    assign timeout_err_o = timeout && !clr_i;
    assign busy_o        = (state_q == ARB_LOCK);
    assign gnt_id_o      = gnt_q;
    assign beat_cnt_o    = accept ? cnt_inc : cnt_q;

    // Next-state logic: clear wins over everything and leaves rr_q alone;
    // a finished or force-released packet hands priority to the next index.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        gnt_d   = pick_idx;
                        state_d = ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (timeout || (accept && owner_last)) begin
                        state_d = ARB_IDLE;
                        rr_d    = gnt_next;
                        cnt_d   = '0;
                    end else if (accept) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/abr_packer_arb.md
Name: abr_packer_arb

Overview:
- Round-robin arbiter/sequencer that shares one InW->OutW packer FIFO between NumReq write requesters.
- Grant is locked per packet: the winner owns the packer write port until its last beat is accepted.
- Drives the packer's clear input on software clear and, optionally, on a stalled owner.
- Sits between producer engines (e.g. sampler, hash front-ends) and the packer FIFO.

Parameters:
- NumReq, 4, number of requesters (>=2).
- InW, 32, write beat width; equals the packer InW.
- CntW, 16, width of the per-packet beat counter.
- TimeoutCycles, 64, idle-owner cycles before forced release (used only with the optional feature).
- IdxW, $clog2(NumReq), derived; grant index width.

Ports:
- clk_i  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous abort/clear.
- req_valid_i  in  NumReq  per-requester beat valid.
- req_data_i  in  NumReq*InW  requester data; requester k occupies bits [k*InW +: InW].
- req_last_i  in  NumReq  final beat of the packet.
- req_ready_o  out  NumReq  per-requester beat accept.
- pk_wvalid_o  out  1  to packer wvalid_i.
- pk_wdata_o  out  InW  to packer wdata_i.
- pk_wready_i  in  1  from packer wready_o.
- pk_clr_o  out  1  to packer clr_i.
- gnt_id_o  out  IdxW  current owner index.
- busy_o  out  1  a grant is locked.
- beat_cnt_o  out  CntW  beats accepted in the current packet.
- timeout_err_o  out  1  one-cycle pulse on forced release.

Behaviour:
Reset (rst_b low, async):
- state = IDLE, rr_ptr = 0, gnt_q = 0, beat_cnt = 0.
- All outputs 0.

IDLE state:
- req_ready_o = 0 and pk_wvalid_o = 0.
- If any req_valid_i is set, pick the first set bit scanning upward from rr_ptr with wrap-around.
- Register the pick into gnt_q and go to LOCK next cycle. This gives 1 cycle of arbitration latency.
- Arbitration uses valid only; last is ignored in IDLE.

LOCK state (pure combinational steering, no data flop):
- pk_wvalid_o = req_valid_i[gnt_q].
- pk_wdata_o = data slice of gnt_q.
- req_ready_o[gnt_q] = pk_wready_i; all other ready bits are 0.
- Accept = pk_wvalid_o && pk_wready_i. Each accept increments beat_cnt, saturating at all-ones.
- Accept with req_last_i[gnt_q] = 1:
  - next state IDLE, rr_ptr = gnt_q+1 mod NumReq, beat_cnt = 0.
  - A new request in the same cycle is not granted until the following IDLE cycle. Back-to-back packets therefore have a 1-cycle bubble.
- A requester that drops valid mid-packet keeps the lock.
- Requester contract: data and last stay stable while valid is high and ready is low.

Status outputs:
- busy_o = (state == LOCK).
- gnt_id_o = gnt_q, which holds its last value in IDLE.

Clear:
- clr_i high in any state: next state IDLE, beat_cnt = 0, rr_ptr unchanged.
- pk_clr_o = clr_i (combinational) OR the timeout pulse.
- While clr_i is high, req_ready_o = 0 and pk_wvalid_o = 0. Nothing is accepted in the clear cycle.

Fairness:
- Any requester holding valid is granted within NumReq-1 other packets.

Reset mid-packet:
- Returns immediately to reset values. The packer is reset by the same rst_b.

Optional Feature:
- Macro: ABR_PACKER_ARB_TIMEOUT_EN.
- Defined:
  - An idle counter runs in LOCK; it increments on each cycle with req_valid_i[gnt_q] = 0 and resets on valid.
  - On reaching TimeoutCycles, for the same single cycle (registered pulse):
    - pk_clr_o = 1 and timeout_err_o = 1;
    - state goes to IDLE, rr_ptr = gnt_q+1, beat_cnt = 0.
  - clr_i takes priority and suppresses timeout_err_o.
- Undefined:
  - No counter logic is present.
  - timeout_err_o is tied 0 and pk_clr_o = clr_i.
  - The lock is held indefinitely.

Decomposition:
- Package abr_packer_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_LOCK, 1 bit);
  - the default TimeoutCycles constant.
- One sub-module, abr_packer_arb_rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_o, idx_o.
- The top holds the FSM, counters and steering.

Test Plan:
- Single packet:
  - Stimulus: NumReq=4; req 2 sends 4 beats 0x11..0x44 with last on beat 4; pk_wready_i=1.
  - Required: gnt_id_o=2 one cycle after valid; beats appear on pk_wdata_o in order; beat_cnt_o reads 1,2,3,4; busy_o drops the cycle after the last accept.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously with 1-beat packets, starting from reset.
  - Required: grant order 0,1,2,3,0; IDLE bubble between each.
- Backpressure:
  - Stimulus: pk_wready_i=0 for 3 cycles mid-packet.
  - Required: req_ready_o[gnt]=0; pk_wdata_o stable; no beat_cnt change; no other requester gets ready.
- Clear mid-packet:
  - Stimulus: clr_i pulse after beat 2 of req 1.
  - Required: pk_clr_o=1 that cycle; busy_o=0 next; req 1 re-arbitrated with rr_ptr unchanged, so req 1 wins again if still valid.
- Timeout (macro defined, TimeoutCycles=8):
  - Stimulus: owner drops valid after beat 1.
  - Required: after 8 idle cycles, timeout_err_o=1 and pk_clr_o=1 for one cycle; next owner is gnt+1.
- Async reset in LOCK:
  - Stimulus: assert rst_b low in LOCK.
  - Required: all outputs 0 immediately; after release, first grant goes to the lowest valid index from 0.
